// File: rtl/quad_demux_fifo_if.sv
// Stream bus for quad_demux_fifo: one valid/ready input port and four FWFT output channels.
// The in_bcast signal exists only when QDEMUX_BCAST_EN is defined.
interface quad_demux_fifo_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
`ifdef QDEMUX_BCAST_EN
    logic               in_bcast;
`endif
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;

    // Source and consumer side, as seen by the testbench or the surrounding logic
    modport master (
        output in_data, in_sel, in_valid,
`ifdef QDEMUX_BCAST_EN
        output in_bcast,
`endif
        input  in_ready,
        input  out_data, out_valid,
        output out_ready
    );

    // Demultiplexer side
    modport slave (
        input  in_data, in_sel, in_valid,
`ifdef QDEMUX_BCAST_EN
        input  in_bcast,
`endif
        output in_ready,
        output out_data, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/quad_demux_fifo.sv
// Four-way stream demultiplexer with a DEPTH-entry first-word-fall-through FIFO per channel.
// Optional feature macro: QDEMUX_BCAST_EN adds in_bcast, which writes one word into all four FIFOs.
module quad_demux_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    quad_demux_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r    [4][DEPTH];
    logic [PW-1:0]    wr_ptr_r [4];
    logic [PW-1:0]    rd_ptr_r [4];
    logic [CW-1:0]    count_r  [4];

    logic [3:0] full_s;
    logic [3:0] push_s;
    logic [3:0] pop_s;
    logic       in_ready_s;
    logic       bcast_s;

    // Full flags, acceptance and per-channel push/pop strobes
    always_comb begin
        full_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            full_s[k] = (count_r[k] == CW'(DEPTH));
        end
`ifdef QDEMUX_BCAST_EN
        bcast_s = bus.in_bcast;
`else
        bcast_s = 1'b0;
`endif
        // Readiness looks only at registered counts: a popping full FIFO still refuses
        if (bcast_s) begin
            in_ready_s = ~|full_s;
        end else begin
            in_ready_s = ~full_s[bus.in_sel];
        end
        push_s = 4'b0000;
        pop_s  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            push_s[k] = bus.in_valid & in_ready_s & (bcast_s | (bus.in_sel == 2'(k)));
            pop_s[k]  = (count_r[k] != CW'(0)) & bus.out_ready[k];
        end
    end

    // Head words and non-empty flags presented to the consumers
    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            bus.out_data[k*WIDTH +: WIDTH] = mem_r[k][rd_ptr_r[k]];
            bus.out_valid[k]               = (count_r[k] != CW'(0));
        end
        bus.in_ready = in_ready_s;
    end

    // FIFO storage, pointers and occupancy counts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_r[k] <= '0;
                rd_ptr_r[k] <= '0;
                count_r[k]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_r[k][e] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push_s[k]) begin
                    mem_r[k][wr_ptr_r[k]] <= bus.in_data;
                    wr_ptr_r[k]           <= wr_ptr_r[k] + PW'(1);
                end else begin
                    wr_ptr_r[k] <= wr_ptr_r[k];
                end
                if (pop_s[k]) begin
                    rd_ptr_r[k] <= rd_ptr_r[k] + PW'(1);
                end else begin
                    rd_ptr_r[k] <= rd_ptr_r[k];
                end
                case ({push_s[k], pop_s[k]})
                    2'b10:   count_r[k] <= count_r[k] + CW'(1);
                    2'b01:   count_r[k] <= count_r[k] - CW'(1);
                    default: count_r[k] <= count_r[k];
                endcase
            end
        end
    end
endmodule
